// File: rtl/pixel_index_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_index_encoder_pkg
// Brief    : Shared constants, FSM state type and threshold helper for the
//            pixel index encoder.
// Revision : 1.0
// ============================================================================
package pixel_index_encoder_pkg;

    localparam int c_PIXEL_COUNT      = 784;
    localparam int c_INDEX_WIDTH      = 10;
    localparam int c_PIXEL_WIDTH      = 8;
    localparam int c_ACTIVE_THRESHOLD = 128;
    localparam int c_FIFO_DEPTH       = 64;

    localparam logic c_TRUE  = 1'b1;
    localparam logic c_FALSE = 1'b0;

    typedef enum logic [0:0] {
        SCAN = 1'b0,
        DONE = 1'b1
    } scanState_t;

    function automatic logic isActive(input logic [31:0] pixel, input logic [31:0] threshold);
        return (pixel >= threshold) ? c_TRUE : c_FALSE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_index_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : pixel_index_encoder_if
// Brief    : Pixel stream input and Layer 1 index-queue signals of the encoder.
// Revision : 1.0
// ============================================================================
interface pixel_index_encoder_if #(
    parameter int PIX_W = 8,
    parameter int IDX_W = 10
);
    logic             pixelValid;
    logic [PIX_W-1:0] pixelIn;
    logic             pixelReady;
    logic             dequeue;
    logic             inputsRecieved;
    logic [IDX_W-1:0] queueOut;
    logic             queueEmpty;
    logic             queueFinished;
    logic [IDX_W:0]   activeCount;

    // master is the encoder, slave is the pixel source / Layer 1 side
    modport master (
        input  pixelValid, pixelIn, dequeue, inputsRecieved,
        output pixelReady, queueOut, queueEmpty, queueFinished, activeCount
    );

    modport slave (
        output pixelValid, pixelIn, dequeue, inputsRecieved,
        input  pixelReady, queueOut, queueEmpty, queueFinished, activeCount
    );
endinterface
`default_nettype wire

// File: rtl/pixel_index_encoder_index_fifo.sv
`default_nettype none
// ============================================================================
// Module   : index_fifo
// Brief    : Synchronous first-word-fall-through FIFO with flush.
// Revision : 1.0
// ============================================================================
module index_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 64
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic             flush,
    input  wire logic [WIDTH-1:0] dataIn,
    output logic      [WIDTH-1:0] dataOut,
    output logic                  empty,
    output logic                  full
);
    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_PTR_W:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_doPush;
    logic w_doPop;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == (c_PTR_W+1)'(DEPTH));
    // A pop on an empty FIFO is dropped even if a push lands the same cycle
    assign w_doPush = push && !w_full;
    assign w_doPop  = pop && !w_empty;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= dataIn;
        end
    end

    // Storage is not reset, so mask the head while empty
    assign dataOut = w_empty ? '0 : r_mem[r_rdPtr];
    assign empty   = w_empty;
    assign full    = w_full;

endmodule
`default_nettype wire

// File: rtl/pixel_index_encoder.sv
`default_nettype none
// ============================================================================
// Module   : pixel_index_encoder
// Brief    : Thresholds a raster pixel stream and queues active pixel indices
//            for the Layer 1 controller.
// Revision : 1.0
// ============================================================================
module pixel_index_encoder
    import pixel_index_encoder_pkg::*;
#(
    parameter int PIXELS    = c_PIXEL_COUNT,
    parameter int IDX_W     = c_INDEX_WIDTH,
    parameter int PIX_W     = c_PIXEL_WIDTH,
    parameter int THRESHOLD = c_ACTIVE_THRESHOLD,
    parameter int DEPTH     = c_FIFO_DEPTH
) (
    input  wire logic              clk,
    input  wire logic              reset,
    pixel_index_encoder_if.master  encBus
);
    scanState_t       r_state;
    logic [IDX_W-1:0] r_pixelIndex;
    logic [IDX_W:0]   r_activeCount;

    logic [PIX_W-1:0] w_pixel;
    logic             w_fifoFull;
    logic             w_fifoEmpty;
    logic [IDX_W-1:0] w_fifoOut;
    logic             w_pixelReady;
    logic             w_accept;
    logic             w_push;
    logic             w_flush;
    logic             w_lastPixel;

    assign w_pixel      = encBus.pixelIn;
    // Ready comes from registered state only, never from pixelValid
    assign w_pixelReady = (r_state == SCAN) && !w_fifoFull;
    assign w_accept     = encBus.pixelValid && w_pixelReady;
    assign w_push       = w_accept && isActive(32'(w_pixel), 32'(THRESHOLD));
    assign w_flush      = (r_state == DONE) && encBus.inputsRecieved;
    assign w_lastPixel  = (r_pixelIndex == IDX_W'(PIXELS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= SCAN;
            r_pixelIndex  <= '0;
            r_activeCount <= '0;
        end else begin
            case (r_state)
                SCAN: begin
                    if (w_accept) begin
                        r_pixelIndex <= r_pixelIndex + 1'b1;
                        if (w_push) begin
                            r_activeCount <= r_activeCount + 1'b1;
                        end
                        if (w_lastPixel) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (encBus.inputsRecieved) begin
                        r_state       <= SCAN;
                        r_pixelIndex  <= '0;
                        r_activeCount <= '0;
                    end
                end
                default: begin
                    r_state <= SCAN;
                end
            endcase
        end
    end

    index_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (DEPTH)
    ) u_indexFifo (
        .clk     (clk),
        .reset   (reset),
        .push    (w_push),
        .pop     (encBus.dequeue),
        .flush   (w_flush),
        .dataIn  (r_pixelIndex),
        .dataOut (w_fifoOut),
        .empty   (w_fifoEmpty),
        .full    (w_fifoFull)
    );

    assign encBus.pixelReady    = w_pixelReady;
    assign encBus.queueOut      = w_fifoOut;
    assign encBus.queueEmpty    = w_fifoEmpty;
    assign encBus.queueFinished = (r_state == DONE);
    assign encBus.activeCount   = r_activeCount;

endmodule
`default_nettype wire

// File: tb/tb_pixel_index_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_index_encoder
// Brief    : Directed self-checking bench for pixel_index_encoder.
// Revision : 1.0
// ============================================================================
module tb_pixel_index_encoder;
    localparam int PIXELS = 784;
    localparam int DEPTH  = 64;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pixel_index_encoder_if #(.PIX_W(8), .IDX_W(10)) bus ();

    pixel_index_encoder #(
        .PIXELS    (PIXELS),
        .IDX_W     (10),
        .PIX_W     (8),
        .THRESHOLD (128),
        .DEPTH     (DEPTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .encBus (bus)
    );

    int checkCount = 0;
    int passCount  = 0;
    logic [7:0] img [PIXELS];
    int feedIdx = 0;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearImg(input logic [7:0] v);
        for (int i = 0; i < PIXELS; i++) img[i] = v;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        bus.pixelValid = 1'b0;
        bus.pixelIn = '0;
        bus.dequeue = 1'b0;
        bus.inputsRecieved = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        feedIdx = 0;
    endtask

    task automatic pulseRecieved();
        bus.inputsRecieved = 1'b1;
        tick();
        bus.inputsRecieved = 1'b0;
    endtask

    task automatic popOne();
        bus.dequeue = 1'b1;
        tick();
        bus.dequeue = 1'b0;
    endtask

    // Present pixels until n of them have been accepted (bounded)
    task automatic feed(input int n);
        int got = 0;
        int budget = 0;
        logic acc;
        while (got < n && budget < 4 * n + 10) begin
            bus.pixelValid = 1'b1;
            bus.pixelIn = (feedIdx < PIXELS) ? img[feedIdx] : 8'd0;
            acc = bus.pixelReady;
            tick();
            if (acc) begin
                got++;
                feedIdx++;
            end
            budget++;
        end
        bus.pixelValid = 1'b0;
        checkValue("feedAccepted", got, n);
    endtask

    initial begin
        int expHead;
        int orderErr;
        int n;
        logic acc;

        applyReset();
        checkValue("rstEmpty", bus.queueEmpty, 1);
        checkValue("rstFinished", bus.queueFinished, 0);
        checkValue("rstActive", bus.activeCount, 0);
        checkValue("rstReady", bus.pixelReady, 1);
        checkValue("rstQueueOut", bus.queueOut, 0);

        // Sparse image: 3 and 5 active, 6 just below threshold
        clearImg(8'd0);
        img[3] = 8'd200; img[5] = 8'd128; img[6] = 8'd127;
        feed(4);
        checkValue("sparseFirstEmpty", bus.queueEmpty, 0);
        checkValue("sparseFirstOut", bus.queueOut, 3);
        feed(779);
        checkValue("sparseNotDoneYet", bus.queueFinished, 0);
        checkValue("sparseReadyBeforeLast", bus.pixelReady, 1);
        feed(1);
        checkValue("sparseFinished", bus.queueFinished, 1);
        checkValue("sparseReadyLow", bus.pixelReady, 0);
        checkValue("sparseActive", bus.activeCount, 2);
        checkValue("sparseHead0", bus.queueOut, 3);
        popOne();
        checkValue("sparseHead1", bus.queueOut, 5);
        checkValue("sparseNotEmpty", bus.queueEmpty, 0);
        popOne();
        checkValue("sparseDrained", bus.queueEmpty, 1);
        popOne();
        checkValue("popEmptyStillEmpty", bus.queueEmpty, 1);
        checkValue("popEmptyActive", bus.activeCount, 2);
        checkValue("popEmptyFinished", bus.queueFinished, 1);
        pulseRecieved();
        checkValue("rearmReady", bus.pixelReady, 1);
        checkValue("rearmFinished", bus.queueFinished, 0);
        checkValue("rearmActive", bus.activeCount, 0);
        feedIdx = 0;

        // Blank image, with an inputsRecieved pulse mid-scan that must be ignored
        clearImg(8'd0);
        feed(100);
        pulseRecieved();
        checkValue("scanRecievedFinished", bus.queueFinished, 0);
        checkValue("scanRecievedReady", bus.pixelReady, 1);
        feed(684);
        checkValue("blankFinished", bus.queueFinished, 1);
        checkValue("blankEmpty", bus.queueEmpty, 1);
        checkValue("blankActive", bus.activeCount, 0);
        checkValue("blankReadyLow", bus.pixelReady, 0);
        pulseRecieved();
        checkValue("blankRearmReady", bus.pixelReady, 1);
        feedIdx = 0;

        // Reset in the middle of a scan
        clearImg(8'd0);
        for (int i = 0; i < 5; i++) img[i] = 8'd255;
        feed(300);
        checkValue("midActive", bus.activeCount, 5);
        checkValue("midNotEmpty", bus.queueEmpty, 0);
        applyReset();
        checkValue("midRstEmpty", bus.queueEmpty, 1);
        checkValue("midRstFinished", bus.queueFinished, 0);
        checkValue("midRstActive", bus.activeCount, 0);
        checkValue("midRstReady", bus.pixelReady, 1);
        clearImg(8'd0);
        img[1] = 8'd255;
        feed(2);
        checkValue("restartIndex", bus.queueOut, 1);
        checkValue("restartActive", bus.activeCount, 1);

        // Push and pop together at half occupancy
        applyReset();
        clearImg(8'd255);
        feed(32);
        checkValue("halfActive", bus.activeCount, 32);
        for (int c = 0; c < 10; c++) begin
            bus.pixelValid = 1'b1;
            bus.pixelIn = img[feedIdx];
            bus.dequeue = 1'b1;
            acc = bus.pixelReady;
            tick();
            if (acc) feedIdx++;
        end
        bus.pixelValid = 1'b0;
        bus.dequeue = 1'b0;
        checkValue("halfPushes", feedIdx, 42);
        expHead = 10; orderErr = 0; n = 0;
        while (!bus.queueEmpty && n < 100) begin
            bus.dequeue = 1'b1;
            if (bus.queueOut != 10'(expHead)) orderErr++;
            expHead++;
            n++;
            tick();
        end
        bus.dequeue = 1'b0;
        checkValue("halfOccupancy", n, 32);
        checkValue("halfOrder", orderErr, 0);

        // Backpressure with every pixel active
        applyReset();
        clearImg(8'd255);
        feed(64);
        checkValue("fullReadyLow", bus.pixelReady, 0);
        checkValue("fullActive", bus.activeCount, 64);
        bus.pixelValid = 1'b1;
        bus.pixelIn = img[feedIdx];
        bus.dequeue = 1'b1;
        tick();
        bus.dequeue = 1'b0;
        checkValue("fullPopReady", bus.pixelReady, 1);
        checkValue("fullPopNoPush", bus.activeCount, 64);
        checkValue("fullPopHead", bus.queueOut, 1);
        tick();
        feedIdx++;
        checkValue("idx64Active", bus.activeCount, 65);
        checkValue("idx64ReadyLow", bus.pixelReady, 0);
        expHead = 1; orderErr = 0; n = 0;
        while (!(bus.queueFinished && bus.queueEmpty) && n < 3000) begin
            bus.pixelValid = 1'b1;
            bus.pixelIn = (feedIdx < PIXELS) ? img[feedIdx] : 8'd0;
            bus.dequeue = 1'b1;
            acc = bus.pixelReady;
            if (!bus.queueEmpty) begin
                if (bus.queueOut != 10'(expHead)) orderErr++;
                expHead++;
            end
            tick();
            if (acc) feedIdx++;
            n++;
        end
        bus.pixelValid = 1'b0;
        bus.dequeue = 1'b0;
        checkValue("bpFinished", bus.queueFinished, 1);
        checkValue("bpEmpty", bus.queueEmpty, 1);
        checkValue("bpPopped", expHead, 784);
        checkValue("bpOrder", orderErr, 0);
        checkValue("bpActive", bus.activeCount, 784);
        checkValue("bpAccepted", feedIdx, 784);

        // Back-to-back images with unread entries at re-arm
        pulseRecieved();
        feedIdx = 0;
        clearImg(8'd0);
        img[10] = 8'd255; img[20] = 8'd255; img[30] = 8'd255;
        feed(784);
        checkValue("b2bActive1", bus.activeCount, 3);
        checkValue("b2bHead1", bus.queueOut, 10);
        pulseRecieved();
        checkValue("b2bFlushEmpty", bus.queueEmpty, 1);
        checkValue("b2bFlushActive", bus.activeCount, 0);
        checkValue("b2bFlushFinished", bus.queueFinished, 0);
        checkValue("b2bFlushReady", bus.pixelReady, 1);
        feedIdx = 0;
        clearImg(8'd0);
        img[7] = 8'd255;
        feed(784);
        checkValue("b2bHead2", bus.queueOut, 7);
        checkValue("b2bActive2", bus.activeCount, 1);
        checkValue("b2bFinished2", bus.queueFinished, 1);
        popOne();
        checkValue("b2bDrained2", bus.queueEmpty, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks so far %0d/%0d", passCount, checkCount);
        $fatal(1);
    end

endmodule
`default_nettype wire
